// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI monarch.
// Contents: transfer FSM state encoding used by spi_mnrch_gen.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NEXT  = 2'd1,
        FINAL = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI monarch.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   ld       : hold/reload divider at 3P/4-1 (SCLK high, mid-way through its high phase)
//   SCLK     : divider MSB, period P = 2^DIV_W clk
//   shft     : shift strobe for the datapath
//   full     : divider at P-1 (end of an SCLK period)
module spi_sclk_gen #(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    output logic SCLK,
    output logic shft,
    output logic full
);

    localparam logic [DIV_W-1:0] LD_VAL   = DIV_W'((3 << (DIV_W - 2)) - 1);
    localparam logic [DIV_W-1:0] HALF_VAL = DIV_W'(1 << (DIV_W - 1));
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk) begin
        if (rst || ld) begin
            div_q <= LD_VAL;
        end else begin
            div_q <= div_q + ONE;
        end
    end

    assign SCLK = div_q[DIV_W-1];
    // Decoded at P/2 so the shift register updates on the same edge the
    // divider steps to P/2+1, one clk after the SCLK rising edge.
    assign shft = (div_q == HALF_VAL);
    assign full = &div_q;

endmodule

// File: rtl/spi_mnrch_gen.sv
// Parametrised SPI monarch: one full-duplex DATA_W-bit transfer per snd pulse
// to the slave selected by ss_sel. SPI mode 3 (SCLK idles high, data sampled
// by both sides around the SCLK rising edge).
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   snd      : start request, honoured only when idle
//   cmd      : word to transmit, captured on accept
//   ss_sel   : slave index, captured on accept (out-of-range selects none)
//   MISO     : serial data from slave
//   SCLK     : serial clock
//   MOSI     : serial data to slave
//   SS_n     : active-low slave selects, at most one low
//   busy     : transfer in progress
//   done     : level, set at transfer end, cleared on next accept
//   resp     : shift register; received word once done is high
module spi_mnrch_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DIV_W     = 5,
    parameter int NUM_SS    = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              snd,
    input  logic [DATA_W-1:0]                                 cmd,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0]    ss_sel,
    input  logic                                              MISO,
    output logic                                              SCLK,
    output logic                                              MOSI,
    output logic [NUM_SS-1:0]                                 SS_n,
    output logic                                              busy,
    output logic                                              done,
    output logic [DATA_W-1:0]                                 resp
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    spi_state_t          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shreg_q, shreg_shift;
    logic [NUM_SS-1:0]   ss_n_q, ss_dec;
    logic                done_q;

    logic init, set_done, shift_en, ld, shft, full;

    spi_sclk_gen #(
        .DIV_W(DIV_W)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .SCLK (SCLK),
        .shft (shft),
        .full (full)
    );

    assign init     = (state_q == IDLE) && snd;
    assign set_done = (state_q == FINAL) && full;
    assign shift_en = (state_q == NEXT) && shft;
    assign ld       = (state_q == IDLE) || set_done;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (snd) state_d = NEXT;
            NEXT:    if (bit_cnt_q == CNT_LAST) state_d = FINAL;
            FINAL:   if (full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range indices match no line, so every select stays high.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            ss_dec[i] = (32'(ss_sel) != i);
        end
    end

    // Shift toward the outgoing end; MISO enters at the far end so that with
    // LSB-first the first received bit lands in bit 0.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shreg_shift = {shreg_q[DATA_W-2:0], MISO};
            assign MOSI        = shreg_q[DATA_W-1];
        end else begin : g_lsb
            assign shreg_shift = {MISO, shreg_q[DATA_W-1:1]};
            assign MOSI        = shreg_q[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (init) begin
            bit_cnt_q <= '0;
            shreg_q   <= cmd;
        end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
            shreg_q   <= shreg_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_n_q <= '1;
            done_q <= 1'b0;
        end else if (init) begin
            ss_n_q <= ss_dec;
            done_q <= 1'b0;
        end else if (set_done) begin
            ss_n_q <= '1;
            done_q <= 1'b1;
        end
    end

    assign SS_n = ss_n_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign resp = shreg_q;

endmodule

// File: tb/tb_spi_mnrch_gen.sv
module tb_spi_mnrch_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 16-bit, P=32, four selects, MSB first
    logic        snd_a, miso_a, sclk_a, mosi_a, busy_a, done_a;
    logic [15:0] cmd_a, resp_a, slv_a;
    logic [1:0]  sel_a;
    logic [3:0]  ss_n_a;

    // Instance B: 8-bit, P=8, one select, LSB first
    logic        snd_b, miso_b, sclk_b, mosi_b, busy_b, done_b;
    logic [7:0]  cmd_b, resp_b, slv_b;
    logic [0:0]  sel_b;
    logic [0:0]  ss_n_b;

    spi_mnrch_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(4), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .rst(rst), .snd(snd_a), .cmd(cmd_a), .ss_sel(sel_a), .MISO(miso_a),
        .SCLK(sclk_a), .MOSI(mosi_a), .SS_n(ss_n_a), .busy(busy_a), .done(done_a),
        .resp(resp_a)
    );

    spi_mnrch_gen #(.DATA_W(8), .DIV_W(3), .NUM_SS(1), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst(rst), .snd(snd_b), .cmd(cmd_b), .ss_sel(sel_b), .MISO(miso_b),
        .SCLK(sclk_b), .MOSI(mosi_b), .SS_n(ss_n_b), .busy(busy_b), .done(done_b),
        .resp(resp_b)
    );

    // Mode-3 slave models: drive MISO after each SCLK fall, capture MOSI on each rise.
    logic        sclk_a_p, sclk_b_p, first_b;
    logic [15:0] rx_a;
    logic [7:0]  rx_b;
    int          sidx_a, sidx_b, rises_a, rises_b;

    always @(posedge clk) begin
        sclk_a_p <= sclk_a;
        if (!busy_a) begin
            sidx_a  <= 0;
            rises_a <= 0;
        end else begin
            if (sclk_a_p && !sclk_a && sidx_a < 16) begin
                miso_a <= slv_a[15-sidx_a];
                sidx_a <= sidx_a + 1;
            end
            if (!sclk_a_p && sclk_a) begin
                rx_a    <= {rx_a[14:0], mosi_a};
                rises_a <= rises_a + 1;
            end
        end
    end

    always @(posedge clk) begin
        sclk_b_p <= sclk_b;
        if (!busy_b) begin
            sidx_b  <= 0;
            rises_b <= 0;
        end else begin
            if (sclk_b_p && !sclk_b && sidx_b < 8) begin
                miso_b <= slv_b[sidx_b];
                sidx_b <= sidx_b + 1;
            end
            if (!sclk_b_p && sclk_b) begin
                rx_b    <= {mosi_b, rx_b[7:1]};
                rises_b <= rises_b + 1;
                if (rises_b == 0) first_b <= mosi_b;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transfer on A; optional snd pulse at cycle pulse_at after accept.
    task automatic xfer_a(input logic [15:0] c, input logic [15:0] s, input logic [1:0] sel,
                          input int pulse_at, output int lat, output logic [15:0] rsp,
                          output logic [15:0] mo, output int nr, output logic [3:0] ss_mid,
                          output logic bz0, output int ndone, output logic [3:0] ss_end);
        int   k;
        logic dp;
        ss_mid = 4'hx;
        @(negedge clk);
        cmd_a = c; slv_a = s; sel_a = sel; snd_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        snd_a = 1'b0; k = 0; bz0 = busy_a; dp = done_a; ndone = 0;
        while (!done_a && k < 2000) begin
            if (k == pulse_at) begin
                snd_a = 1'b1; cmd_a = ~c;
            end else begin
                snd_a = 1'b0;
            end
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 260) ss_mid = ss_n_a;
            if (done_a && !dp) ndone++;
            dp = done_a;
        end
        lat = k; rsp = resp_a; mo = rx_a; nr = rises_a;
        snd_a = 1'b0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done_a && !dp) ndone++;
            dp = done_a;
        end
        ss_end = ss_n_a;
    endtask

    task automatic xfer_b(input logic [7:0] c, input logic [7:0] s, input logic [0:0] sel,
                          output int lat, output logic [7:0] rsp, output logic [7:0] mo,
                          output int nr, output logic fb, output logic [0:0] ss_mid,
                          output logic [0:0] ss_end);
        int k;
        ss_mid = 1'bx;
        @(negedge clk);
        cmd_b = c; slv_b = s; sel_b = sel; snd_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        snd_b = 1'b0; k = 0;
        while (!done_b && k < 500) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 30) ss_mid = ss_n_b;
        end
        lat = k; rsp = resp_b; mo = rx_b; nr = rises_b; fb = first_b;
        repeat (4) @(negedge clk);
        ss_end = ss_n_b;
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] slv;
        logic [1:0]  sel;
        logic [15:0] exp_resp;
        logic [15:0] exp_mosi;
        logic [3:0]  exp_ss;
    } vec_a_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] slv;
        logic [0:0] sel;
        logic [7:0] exp_resp;
        logic [7:0] exp_mosi;
        logic       exp_first;
        logic [0:0] exp_ss;
    } vec_b_t;

    vec_a_t va[4];
    vec_b_t vb[2];

    int          lat, nr, ndone, k;
    logic [15:0] rsp, mo;
    logic [7:0]  rsp8, mo8;
    logic [3:0]  ss_mid, ss_end;
    logic [0:0]  ss_mid1, ss_end1;
    logic        bz0, fb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        va[0] = '{16'hA5C3, 16'h3C5A, 2'd0, 16'h3C5A, 16'hA5C3, 4'b1110};
        va[1] = '{16'hA5C3, 16'h3C5A, 2'd2, 16'h3C5A, 16'hA5C3, 4'b1011};
        va[2] = '{16'hFFFF, 16'h0000, 2'd1, 16'h0000, 16'hFFFF, 4'b1101};
        va[3] = '{16'h0001, 16'h8000, 2'd3, 16'h8000, 16'h0001, 4'b0111};
        vb[0] = '{8'h01, 8'hB4, 1'b0, 8'hB4, 8'h01, 1'b1, 1'b0};
        vb[1] = '{8'hC6, 8'h3D, 1'b1, 8'h3D, 8'hC6, 1'b0, 1'b1};

        rst = 1'b1;
        snd_a = 1'b0; cmd_a = '0; sel_a = '0; slv_a = '0; miso_a = 1'b0;
        snd_b = 1'b0; cmd_b = '0; sel_b = '0; slv_b = '0; miso_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_a", 32'(ss_n_a), 32'hF);
        chk("rst_sclk_a", 32'(sclk_a), 32'h1);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h0);
        chk("rst_mosi_a", 32'(mosi_a), 32'h0);
        chk("rst_resp_a", 32'(resp_a), 32'h0);
        chk("rst_ss_b", 32'(ss_n_b), 32'h1);
        chk("rst_sclk_b", 32'(sclk_b), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            xfer_a(va[i].cmd, va[i].slv, va[i].sel, -1, lat, rsp, mo, nr, ss_mid, bz0, ndone,
                   ss_end);
            chk($sformatf("a%0d_latency", i), 32'(lat), 32'd521);
            chk($sformatf("a%0d_resp", i), 32'(rsp), 32'(va[i].exp_resp));
            chk($sformatf("a%0d_mosi", i), 32'(mo), 32'(va[i].exp_mosi));
            chk($sformatf("a%0d_rises", i), 32'(nr), 32'd16);
            chk($sformatf("a%0d_ss_mid", i), 32'(ss_mid), 32'(va[i].exp_ss));
            chk($sformatf("a%0d_ss_end", i), 32'(ss_end), 32'hF);
            chk($sformatf("a%0d_busy0", i), 32'(bz0), 32'h1);
            chk($sformatf("a%0d_ndone", i), 32'(ndone), 32'd1);
            chk($sformatf("a%0d_busy_end", i), 32'(busy_a), 32'h0);
        end

        for (int i = 0; i < 2; i++) begin
            xfer_b(vb[i].cmd, vb[i].slv, vb[i].sel, lat, rsp8, mo8, nr, fb, ss_mid1, ss_end1);
            chk($sformatf("b%0d_latency", i), 32'(lat), 32'd67);
            chk($sformatf("b%0d_resp", i), 32'(rsp8), 32'(vb[i].exp_resp));
            chk($sformatf("b%0d_mosi", i), 32'(mo8), 32'(vb[i].exp_mosi));
            chk($sformatf("b%0d_first", i), 32'(fb), 32'(vb[i].exp_first));
            chk($sformatf("b%0d_rises", i), 32'(nr), 32'd8);
            chk($sformatf("b%0d_ss_mid", i), 32'(ss_mid1), 32'(vb[i].exp_ss));
            chk($sformatf("b%0d_ss_end", i), 32'(ss_end1), 32'h1);
        end

        // snd pulsed mid-transfer with a different cmd is ignored
        xfer_a(16'h1357, 16'h9BDF, 2'd1, 200, lat, rsp, mo, nr, ss_mid, bz0, ndone, ss_end);
        chk("mid_snd_latency", 32'(lat), 32'd521);
        chk("mid_snd_resp", 32'(rsp), 32'h9BDF);
        chk("mid_snd_mosi", 32'(mo), 32'h1357);
        chk("mid_snd_ndone", 32'(ndone), 32'd1);
        chk("mid_snd_ss_mid", 32'(ss_mid), 32'b1101);
        chk("mid_snd_busy_end", 32'(busy_a), 32'h0);

        // reset right after shift 7 (edge 218 after accept)
        @(negedge clk);
        cmd_a = 16'h1234; slv_a = 16'hFEDC; sel_a = 2'd0; snd_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        snd_a = 1'b0; k = 0;
        while (k < 218) begin
            @(posedge clk); k++;
            @(negedge clk);
        end
        chk("rstmid_rises", 32'(rises_a), 32'd7);
        chk("rstmid_ss_before", 32'(ss_n_a), 32'b1110);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ss", 32'(ss_n_a), 32'hF);
        chk("rstmid_sclk", 32'(sclk_a), 32'h1);
        chk("rstmid_done", 32'(done_a), 32'h0);
        chk("rstmid_busy", 32'(busy_a), 32'h0);
        chk("rstmid_resp", 32'(resp_a), 32'h0);
        xfer_a(16'h0F0F, 16'hC3A5, 2'd3, -1, lat, rsp, mo, nr, ss_mid, bz0, ndone, ss_end);
        chk("after_rst_latency", 32'(lat), 32'd521);
        chk("after_rst_resp", 32'(rsp), 32'hC3A5);
        chk("after_rst_mosi", 32'(mo), 32'h0F0F);
        chk("after_rst_ndone", 32'(ndone), 32'd1);

        // snd held high: back-to-back transfers with one idle cycle between
        @(negedge clk);
        cmd_a = 16'hA5C3; slv_a = 16'h3C5A; sel_a = 2'd0; snd_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!done_a && k < 2000) begin
            @(posedge clk); k++;
            @(negedge clk);
        end
        chk("b2b_lat1", 32'(k), 32'd521);
        chk("b2b_resp1", 32'(resp_a), 32'h3C5A);
        chk("b2b_busy_gap", 32'(busy_a), 32'h0);
        chk("b2b_ss_gap", 32'(ss_n_a), 32'hF);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done_clr", 32'(done_a), 32'h0);
        chk("b2b_busy2", 32'(busy_a), 32'h1);
        chk("b2b_ss2", 32'(ss_n_a), 32'b1110);
        k = 0;
        while (!done_a && k < 2000) begin
            @(posedge clk); k++;
            @(negedge clk);
        end
        snd_a = 1'b0;
        chk("b2b_lat2", 32'(k), 32'd521);
        chk("b2b_resp2", 32'(resp_a), 32'h3C5A);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
